// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // IDLE accepts requests; MERGE is the write cycle of a sub-word store
  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. Grant is combinational; only the last winner
// is stored. Reset leaves port 1 as last winner so port 0 takes the first tie.
module rr_arbiter2
  import dmem_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] grant
);

  logic last_grant;

  // Single requester wins outright; a tie goes to the port that lost last time
  always_comb begin
    grant = '0;
    if (en) begin
      if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
      else            grant = req_valid;
    end
  end

  // Every grant is an accept, so record its winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the 1R1W word memory between the load/store unit (port 0) and the
// debug loader (port 1). Loads and word stores take one cycle; byte and half
// stores read the old word in the accept cycle and write the merged word in
// a single MERGE cycle.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH) + 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req_valid,
  output logic [NUM_PORTS-1:0]           req_ready,
  input  logic [NUM_PORTS-1:0]           req_we,
  input  logic [NUM_PORTS-1:0][1:0]      req_size,
  input  logic [NUM_PORTS-1:0][AW-1:0]   req_addr,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]           resp_valid,
  output logic                           resp_err,
  output logic [WIDTH-1:0]               resp_rdata,
  output logic [AW-1:0]                  mem_rd_addr,
  output logic [AW-1:0]                  mem_wr_addr,
  output logic [WIDTH-1:0]               mem_wr_din,
  output logic                           mem_we,
  input  logic [WIDTH-1:0]               mem_rd_dout
);

  state_t                 state, state_nx;
  logic                   arb_en;
  logic [NUM_PORTS-1:0]   grant;
  logic                   gsel, accept;
  logic                   s_we, s_err, word_st, sub_st;
  logic [1:0]             s_sz;
  logic [AW-1:0]          s_addr;
  logic [WIDTH-1:0]       s_wd;

  logic                   lat_port, lat_half;
  logic [AW-1:0]          lat_addr;
  logic [15:0]            lat_wd;
  logic [WIDTH-1:0]       old_word, lane_data, merged;
  logic [3:0]             lane_mask;

  // Arbitration only while idle and out of reset, so ready stays low in reset
  assign arb_en = (state == IDLE) && rst;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign gsel   = grant[1];
  assign accept = |grant;
  assign s_we   = req_we[gsel];
  assign s_sz   = req_size[gsel];
  assign s_addr = req_addr[gsel];
  assign s_wd   = req_wdata[gsel];

  assign s_err   = (s_sz == SZ_ILL) ||
                   ((s_sz == SZ_HALF) && s_addr[0]) ||
                   ((s_sz == SZ_WORD) && (s_addr[1:0] != 2'b00));
  assign word_st = accept && s_we && !s_err && (s_sz == SZ_WORD);
  assign sub_st  = accept && s_we && !s_err && (s_sz != SZ_WORD);

  // Lane select and replicated store data for the read-modify-write
  always_comb begin
    lane_mask = lat_half ? (lat_addr[1] ? 4'b1100 : 4'b0011)
                         : (4'b0001 << lat_addr[1:0]);
    lane_data = lat_half ? {2{lat_wd}} : {4{lat_wd[7:0]}};
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign merged[8*l +: 8] = lane_mask[l] ? lane_data[8*l +: 8] : old_word[8*l +: 8];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and memory-side outputs
  always_comb begin
    state_nx    = state;
    req_ready   = grant;
    mem_rd_addr = accept ? s_addr : '0;
    mem_we      = 1'b0;
    mem_wr_addr = '0;
    mem_wr_din  = '0;
    case (state)
      IDLE: begin
        if (sub_st) state_nx = MERGE;
        if (word_st) begin
          mem_we      = 1'b1;
          mem_wr_addr = s_addr;
          mem_wr_din  = s_wd;
        end
      end
      MERGE: begin
        state_nx    = IDLE;
        mem_we      = 1'b1;
        mem_wr_addr = lat_addr;
        mem_wr_din  = merged;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Response pulse one cycle after accept (or after MERGE) and sub-word capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      old_word   <= '0;
      lat_port   <= 1'b0;
      lat_half   <= 1'b0;
      lat_addr   <= '0;
      lat_wd     <= '0;
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (state == MERGE) begin
        resp_valid <= lat_port ? 2'b10 : 2'b01;
      end else if (accept) begin
        if (s_err) begin
          resp_valid <= grant;
          resp_err   <= 1'b1;
        end else if (!s_we) begin
          resp_valid <= grant;
          resp_rdata <= mem_rd_dout;
        end else if (s_sz == SZ_WORD) begin
          resp_valid <= grant;
        end else begin
          old_word <= mem_rd_dout;
          lat_port <= gsel;
          lat_half <= (s_sz == SZ_HALF);
          lat_addr <= s_addr;
          lat_wd   <= s_wd[15:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised and directed bench for dmem_port_arbiter with a transaction-level
// model of arbitration, responses and memory contents.
module tb_dmem_port_arbiter;

  localparam int AW = 4;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic [3:0]  addr;
    logic [31:0] wd;
  } rq_t;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    int port;
    int cyc;
  } acc_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_we = '0;
  logic [1:0][1:0]   req_size = '0;
  logic [1:0][3:0]   req_addr = '0;
  logic [1:0][31:0]  req_wdata = '0;
  logic [1:0]        req_ready, resp_valid;
  logic              resp_err, mem_we;
  logic [31:0]       resp_rdata, mem_wr_din, mem_rd_dout;
  logic [3:0]        mem_rd_addr, mem_wr_addr;

  int chk = 0, errs = 0, cyc = 0;

  rq_t  pq0[$], pq1[$];
  rsp_t exp_q[$], rsp_log[$];
  acc_t acc_log[$];

  logic [31:0] mem [4];
  logic [31:0] ref_mem [4] = '{default: 32'h0};
  int          m_last  = 1;
  bit          m_merge = 0;
  int          m_port  = 0;
  logic [3:0]  m_addr  = '0;
  logic [31:0] m_word  = '0;

  dmem_port_arbiter #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_din(mem_wr_din), .mem_we(mem_we), .mem_rd_dout(mem_rd_dout)
  );

  always #5 clk = ~clk;

  // Memory instance: combinational read, write on the clock edge
  assign mem_rd_dout = mem[mem_rd_addr[3:2]];
  always @(posedge clk) if (mem_we) mem[mem_wr_addr[3:2]] <= mem_wr_din;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    logic [1:0]  erdy, acc;
    logic        ewe, e;
    logic [1:0]  sz;
    logic [3:0]  a;
    logic [31:0] w;
    int          p;
    cyc++;
    if (!rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rd_addr", mem_rd_addr, 0);
      check("rst_wr_addr", mem_wr_addr, 0);
      check("rst_wr_din", mem_wr_din, 0);
      m_last  = 1;
      m_merge = 0;
      exp_q.delete();
    end else begin
      erdy = 2'b00;
      if (!m_merge) erdy = (req_valid == 2'b11) ? ((m_last == 0) ? 2'b10 : 2'b01) : req_valid;
      check("ready", req_ready, erdy);

      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        check("resp_valid", resp_valid, 32'd1 << exp_q[0].port);
        check("resp_err", resp_err, exp_q[0].err);
        check("resp_rdata", resp_rdata, exp_q[0].rdata);
        void'(exp_q.pop_front());
      end else begin
        check("resp_quiet", resp_valid, 0);
      end
      if (resp_valid != 0) rsp_log.push_back('{resp_valid[1] ? 1 : 0, resp_err, resp_rdata, cyc});

      acc = req_valid & erdy;
      ewe = 1'b0;
      if (m_merge) begin
        ewe = 1'b1;
        check("merge_addr", mem_wr_addr, m_addr);
        check("merge_din", mem_wr_din, m_word);
        ref_mem[m_addr / 4] = m_word;
        exp_q.push_back('{m_port, 1'b0, 32'h0, cyc + 1});
        m_merge = 0;
      end else if (acc != 0) begin
        p  = acc[1] ? 1 : 0;
        sz = req_size[p];
        a  = req_addr[p];
        m_last = p;
        acc_log.push_back('{p, cyc});
        e = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
        if (e) begin
          exp_q.push_back('{p, 1'b1, 32'h0, cyc + 1});
        end else if (!req_we[p]) begin
          check("ld_rd_addr", mem_rd_addr, a);
          exp_q.push_back('{p, 1'b0, ref_mem[a / 4], cyc + 1});
        end else if (sz == 2) begin
          ewe = 1'b1;
          check("st_wr_addr", mem_wr_addr, a);
          check("st_wr_din", mem_wr_din, req_wdata[p]);
          ref_mem[a / 4] = req_wdata[p];
          exp_q.push_back('{p, 1'b0, 32'h0, cyc + 1});
        end else begin
          check("rmw_rd_addr", mem_rd_addr, a);
          w = ref_mem[a / 4];
          if (sz == 0) w[8*(a % 4) +: 8]  = req_wdata[p][7:0];
          else         w[8*(a % 4) +: 16] = req_wdata[p][15:0];
          m_word  = w;
          m_addr  = a;
          m_port  = p;
          m_merge = 1;
        end
      end
      check("mem_we", mem_we, ewe);
    end
  end

  function automatic rq_t mk(input logic we, input logic [1:0] sz, input logic [3:0] a,
                             input logic [31:0] d);
    rq_t r;
    r.we = we; r.sz = sz; r.addr = a; r.wd = d;
    return r;
  endfunction

  task automatic drive(input int p, input rq_t r);
    req_we[p]    = r.we;
    req_size[p]  = r.sz;
    req_addr[p]  = r.addr;
    req_wdata[p] = r.wd;
    req_valid[p] = 1'b1;
  endtask

  task automatic load_next(input bit gap);
    if (!req_valid[0] && pq0.size() != 0 && (!gap || $urandom_range(0, 2) != 0)) begin
      rq_t r;
      r = pq0.pop_front();
      drive(0, r);
    end
    if (!req_valid[1] && pq1.size() != 0 && (!gap || $urandom_range(0, 2) != 0)) begin
      rq_t r;
      r = pq1.pop_front();
      drive(1, r);
    end
  endtask

  // Hold each request until it transfers, then present the next one
  task automatic run(input bit gap, input int maxcyc);
    int n;
    logic [1:0] f;
    n = 0;
    load_next(gap);
    while ((req_valid != 0 || pq0.size() != 0 || pq1.size() != 0) && n < maxcyc) begin
      @(negedge clk);
      f = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~f;
      load_next(gap);
      n++;
    end
    check("run_in_budget", (n < maxcyc) ? 1 : 0, 1);
    req_valid = '0;
    pq0.delete();
    pq1.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_lost_resp", exp_q.size(), 0);
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    acc_log.delete();
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] sz;
    logic [3:0] a;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Bring memory to a known state
    for (int i = 0; i < 4; i++) pq0.push_back(mk(1, 2, 4'(i * 4), 32'h0));
    run(0, 50);

    // Word store then load on port 0
    clear_logs();
    pq0.push_back(mk(1, 2, 4'h4, 32'hDEADBEEF));
    pq0.push_back(mk(0, 2, 4'h4, 32'h0));
    run(0, 50);
    check("ws_lat", rsp_log[0].cyc - acc_log[0].cyc, 1);
    check("ld_lat", rsp_log[1].cyc - acc_log[1].cyc, 1);
    check("ld_deadbeef", rsp_log[1].rdata, 32'hDEADBEEF);

    // Byte store on port 1 with a port 0 load waiting behind it
    pq0.push_back(mk(1, 2, 4'h8, 32'h11223344));
    run(0, 50);
    clear_logs();
    pq1.push_back(mk(1, 0, 4'h9, 32'h000000AA));
    pq0.push_back(mk(0, 2, 4'h8, 32'h0));
    run(0, 50);
    check("byte_first_port", acc_log[0].port, 1);
    check("byte_lat", rsp_log[0].cyc - acc_log[0].cyc, 2);
    check("merge_stall", acc_log[1].cyc - acc_log[0].cyc, 2);
    check("back_to_back", acc_log[1].cyc, rsp_log[0].cyc);
    check("ld_byte_merged", rsp_log[1].rdata, 32'h1122AA44);

    // Half store, then misaligned half
    clear_logs();
    pq0.push_back(mk(1, 2, 4'h8, 32'h11223344));
    pq0.push_back(mk(1, 1, 4'hA, 32'h0000BEEF));
    pq0.push_back(mk(0, 2, 4'h8, 32'h0));
    pq0.push_back(mk(1, 1, 4'hB, 32'h00001234));
    run(0, 60);
    check("ld_half_merged", rsp_log[2].rdata, 32'hBEEF3344);
    check("mis_half_err", rsp_log[3].err, 1);
    check("mis_half_rdata", rsp_log[3].rdata, 0);
    check("mis_half_nowrite", mem[2], 32'hBEEF3344);

    // Both ports streaming loads alternate, port 0 first after reset
    pulse_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      pq0.push_back(mk(0, 2, 4'h4, 32'h0));
      pq1.push_back(mk(0, 2, 4'h8, 32'h0));
    end
    run(0, 60);
    for (int i = 0; i < 8; i++) check("alt_grant", acc_log[i].port, i % 2);

    // Reset during MERGE drops the pending write
    pq0.push_back(mk(1, 2, 4'hC, 32'h12345678));
    run(0, 50);
    drive(0, mk(1, 0, 4'hD, 32'h00000099));
    @(negedge clk);
    check("rst_merge_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_merge_mem", mem[3], 32'h12345678);
    clear_logs();
    pq0.push_back(mk(0, 2, 4'hC, 32'h0));
    pq1.push_back(mk(0, 2, 4'hC, 32'h0));
    run(0, 50);
    check("rst_first_tie", acc_log[0].port, 0);
    check("rst_merge_ld", rsp_log[0].rdata, 32'h12345678);

    // Store on port 0 then immediate load on port 1
    pulse_reset();
    clear_logs();
    pq0.push_back(mk(1, 2, 4'h0, 32'h00000055));
    pq1.push_back(mk(0, 2, 4'h0, 32'h0));
    run(0, 50);
    check("raw_order", acc_log[0].port, 0);
    check("raw_gap", acc_log[1].cyc - acc_log[0].cyc, 1);
    check("raw_data", rsp_log[1].rdata, 32'h00000055);

    // Random mix on both ports
    for (int i = 0; i < 400; i++) begin
      int r;
      r  = $urandom_range(0, 7);
      sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      a  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 1) == 0) pq0.push_back(mk(1'($urandom_range(0, 1)), sz, a, $urandom));
      else                           pq1.push_back(mk(1'($urandom_range(0, 1)), sz, a, $urandom));
    end
    run(1, 6000);

    for (int i = 0; i < 4; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single read port and single write port of the word-organised 1R1W data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/program loader).
- Round-robin arbitration; valid/ready request handshake; one-cycle response pulse per accepted request.
- Memory writes are full words only, so byte and halfword stores are sequenced as a read-modify-write.
- Sits between the pipeline MEM stage / debug loader and the memory instance.

Parameters:
- WIDTH, 32, data width in bits. Fixed at 32 because byte-lane merging assumes 4 lanes.
- DEPTH, 4, memory depth in words. Must match the memory instance.
- AW, $clog2(DEPTH)+2, byte-address width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- req_valid  in  2  per-requester request valid (bit n = port n)
- req_ready  out  2  per-requester accept; a request transfers when valid&ready
- req_we  in  2  1 = store, 0 = load
- req_size  in  2x2  per port: 00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  2xAW  per-port byte address
- req_wdata  in  2xWIDTH  per-port store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  2  one-cycle completion pulse per port
- resp_err  out  1  qualifies resp_valid: misaligned or illegal size
- resp_rdata  out  WIDTH  full aligned word for loads; 0 for stores and errors
- mem_rd_addr  out  AW  byte address to memory read port (word = addr[AW-1:2])
- mem_wr_addr  out  AW  byte address to memory write port
- mem_wr_din  out  WIDTH  write data
- mem_we  out  1  write enable
- mem_rd_dout  in  WIDTH  combinational read data from memory

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, addresses=0, mem_wr_din=0.
  - Reset in MERGE aborts the pending write: no partial write reaches memory.
- FSM states: IDLE, MERGE.
- IDLE:
  - Grant: if one port is valid, grant it. If both are valid, grant the port != last_grant.
  - req_ready is combinational: only the granted bit is high, and only in IDLE.
  - On accept, last_grant <= granted port.
- Error check, on accept:
  - Error if size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - An error request does no memory write. Next cycle: resp_valid[g]=1, resp_err=1, resp_rdata=0.
- Load, accepted in IDLE:
  - mem_rd_addr=addr in the same cycle.
  - resp_rdata <= mem_rd_dout, registered. resp_valid[g] pulses the next cycle (latency 1).
- Word store, accepted in IDLE:
  - mem_we=1, mem_wr_addr=addr, mem_wr_din=wdata in the same cycle.
  - resp_valid pulses next cycle with resp_rdata=0.
- Byte/half store, accepted in IDLE:
  - mem_rd_addr=addr. Capture mem_rd_dout into old_word. Latch port, addr, size, wdata. Go to MERGE.
- MERGE (exactly 1 cycle):
  - req_ready=00.
  - mem_we=1; mem_wr_addr=latched addr; mem_wr_din = old_word with the lane(s) replaced.
  - Byte: lane addr[1:0] takes wdata[7:0]. Half: lanes addr[1]*2..+1 take wdata[15:0].
  - Return to IDLE. resp_valid pulses the cycle after MERGE (accept-to-response = 2).
- mem_we is high only in the write cycle of a word store or in MERGE; 0 otherwise.
- Back-to-back: a new request may be accepted in the cycle its predecessor's resp_valid is high.
- A store followed immediately by a load to the same word returns the new data, because the write commits at the clock edge before the load cycle.
- A requester holding valid while not granted must keep its request stable; no request is dropped.
- At most one resp_valid bit is high in any cycle.

Decomposition:
- Shared package: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), the FSM state enum (IDLE, MERGE), and NUM_PORTS=2.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant from req_valid, last_grant and an enable. Pure combinational, plus the last_grant register.
- Lane merge logic stays inline.

Test Plan:
- Reset then port0 word store 0xDEADBEEF @0x4 -> mem_we=1 in the accept cycle; resp_valid[0] next cycle. Port0 load @0x4 -> resp_rdata=0xDEADBEEF one cycle after accept.
- Word 0x11223344 @0x8, then port1 byte store 0xAA @0x9 -> ready drops for one cycle (MERGE); load @0x8 returns 0x1122AA44; resp_valid[1] two cycles after accept.
- Half store 0xBEEF @0xA over 0x11223344 -> word reads 0xBEEF3344. Half @0xB -> no write, resp_err=1, resp_rdata=0.
- Both ports valid continuously with loads -> grants alternate 0,1,0,1 starting with port 0 after reset; no starvation.
- Byte store accepted, rst pulled low during MERGE -> memory word unchanged; all outputs 0; after release, first tie goes to port 0.
- Word store 0x55 @0x0 followed immediately by a load @0x0 from the other port -> load returns 0x00000055.
